// File: rtl/mipi_tx_packet_arbiter.sv
// mipi_tx_packet_arbiter: grants the DSI host TX packet port to video (V) or command (C) one whole packet at a time.
// Optional C aging against V starvation is enabled by defining MIPI_TX_ARB_AGING_EN.
module mipi_tx_packet_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int AGE_LIMIT  = 8
) (
  input  logic        clktx,
  input  logic        rst,
  input  logic        v_req,
  input  logic        v_long,
  input  logic [23:0] v_hdr,
  input  logic [31:0] v_payload,
  input  logic        c_req,
  input  logic        c_long,
  input  logic [23:0] c_hdr,
  input  logic [31:0] c_payload,
  input  logic        blank,
  input  logic        host_tx_cmd_ack,
  input  logic        host_tx_active,
  input  logic        host_tx_payload_en,
  input  logic        host_tx_payload_en_last,
  output logic        gnt_v,
  output logic        gnt_c,
  output logic        host_tx_cmd_req,
  output logic [1:0]  host_tx_cmd_vc,
  output logic [5:0]  host_tx_cmd_data_type,
  output logic [15:0] host_tx_cmd_byte_count,
  output logic        host_tx_hs_mode,
  output logic [31:0] host_tx_payload
);
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  typedef enum logic [1:0] {IDLE, REQ, DATA, GAP} state_t;
  state_t state;
  logic is_long;
  logic [GW-1:0] gap_cnt;
  logic pick_c, gap_done;
  logic [23:0] win_hdr;
`ifdef MIPI_TX_ARB_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] age;
  assign pick_c = c_req && blank && (!v_req || int'(age) >= AGE_LIMIT);
  always_ff @(posedge clktx or posedge rst)
    if (rst) age <= '0;
    else if (!c_req || (state == IDLE && pick_c)) age <= '0;
    else if (state == IDLE && v_req && blank && int'(age) < AGE_LIMIT) age <= age + 1'b1;
`else
  assign pick_c = c_req && blank && !v_req;
`endif
  assign win_hdr = pick_c ? c_hdr : v_hdr;
  // the GAP state itself takes one cycle, so GAP_CYCLES of 0 and 1 both hold the grant one cycle
  assign gap_done = int'(gap_cnt) + 1 >= GAP_CYCLES;
  assign host_tx_hs_mode = gnt_v | gnt_c;
  assign host_tx_payload = state != DATA ? '0 : gnt_c ? c_payload : v_payload;
  always_ff @(posedge clktx or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_v <= 1'b0;
      gnt_c <= 1'b0;
      host_tx_cmd_req <= 1'b0;
      host_tx_cmd_vc <= '0;
      host_tx_cmd_data_type <= '0;
      host_tx_cmd_byte_count <= '0;
      is_long <= 1'b0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (v_req || pick_c) begin
          state <= REQ;
          gnt_v <= !pick_c;
          gnt_c <= pick_c;
          host_tx_cmd_req <= 1'b1;
          host_tx_cmd_vc <= win_hdr[7:6];
          host_tx_cmd_data_type <= win_hdr[5:0];
          host_tx_cmd_byte_count <= win_hdr[23:8];
          is_long <= pick_c ? c_long : v_long;
        end
        REQ: if (host_tx_cmd_ack) begin
          host_tx_cmd_req <= 1'b0;
          gap_cnt <= '0;
          state <= (is_long && host_tx_cmd_byte_count != 16'd0) ? DATA : GAP;
        end
        DATA: if (host_tx_payload_en_last) begin
          gap_cnt <= '0;
          state <= GAP;
        end
        GAP: if (gap_done && !host_tx_active) begin
          state <= IDLE;
          gnt_v <= 1'b0;
          gnt_c <= 1'b0;
        end else if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mipi_tx_packet_arbiter.sv
// tb_mipi_tx_packet_arbiter: directed and randomized checks of the TX packet arbiter against a packet-level model.
module tb_mipi_tx_packet_arbiter;
  localparam int GAP = 2;
  localparam int AGE = 8;
  logic clktx = 0, rst = 0;
  logic v_req = 0, v_long = 0, c_req = 0, c_long = 0, blank = 0;
  logic [23:0] v_hdr = 0, c_hdr = 0;
  logic [31:0] v_payload = 0, c_payload = 0;
  logic ack = 0, active = 0, pen = 0, last = 0;
  logic gnt_v, gnt_c, cmd_req, hs_mode;
  logic [1:0] vc;
  logic [5:0] dt;
  logic [15:0] bc;
  logic [31:0] payload;
  always #5 clktx = ~clktx;
  mipi_tx_packet_arbiter #(.GAP_CYCLES(GAP), .AGE_LIMIT(AGE)) dut (
    .clktx(clktx), .rst(rst), .v_req(v_req), .v_long(v_long), .v_hdr(v_hdr), .v_payload(v_payload),
    .c_req(c_req), .c_long(c_long), .c_hdr(c_hdr), .c_payload(c_payload), .blank(blank),
    .host_tx_cmd_ack(ack), .host_tx_active(active), .host_tx_payload_en(pen),
    .host_tx_payload_en_last(last), .gnt_v(gnt_v), .gnt_c(gnt_c), .host_tx_cmd_req(cmd_req),
    .host_tx_cmd_vc(vc), .host_tx_cmd_data_type(dt), .host_tx_cmd_byte_count(bc),
    .host_tx_hs_mode(hs_mode), .host_tx_payload(payload)
  );
  int total = 0, bad = 0;
  // model: owner 0 none / 1 V / 2 C, header outstanding, payload streaming, gap cycles elapsed
  int owner, elapsed;
  bit pend, strm, mlong;
  logic [23:0] mhdr;
`ifdef MIPI_TX_ARB_AGING_EN
  int age;
`endif
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  function automatic void mreset();
    owner = 0; elapsed = 0; pend = 0; strm = 0; mlong = 0; mhdr = 0;
`ifdef MIPI_TX_ARB_AGING_EN
    age = 0;
`endif
  endfunction
  function automatic void mstep();
    bit gv, gc, aged;
    gv = 0; gc = 0; aged = 0;
`ifdef MIPI_TX_ARB_AGING_EN
    aged = age >= AGE;
`endif
    if (rst) begin mreset(); return; end
    if (owner == 0) begin
      gc = c_req && blank && (!v_req || aged);
      gv = v_req && !gc;
      if (gv || gc) begin
        owner = gv ? 1 : 2;
        mhdr = gv ? v_hdr : c_hdr;
        mlong = gv ? v_long : c_long;
        pend = 1;
      end
    end else if (pend) begin
      if (ack) begin pend = 0; strm = mlong && mhdr[23:8] != 0; elapsed = 0; end
    end else if (strm) begin
      if (last) begin strm = 0; elapsed = 0; end
    end else begin
      elapsed++;
      if (elapsed >= GAP && !active) owner = 0;
    end
`ifdef MIPI_TX_ARB_AGING_EN
    if (!c_req || gc) age = 0;
    else if (gv && blank && age < AGE) age++;
`endif
  endfunction
  task automatic compare();
    chk("gnt_v", 32'(gnt_v), 32'(owner == 1));
    chk("gnt_c", 32'(gnt_c), 32'(owner == 2));
    chk("hs_mode", 32'(hs_mode), 32'(owner != 0));
    chk("cmd_req", 32'(cmd_req), 32'(pend));
    chk("vc", 32'(vc), 32'(mhdr[7:6]));
    chk("dt", 32'(dt), 32'(mhdr[5:0]));
    chk("byte_count", 32'(bc), 32'(mhdr[23:8]));
    chk("payload", payload, strm ? (owner == 1 ? v_payload : c_payload) : 32'd0);
  endtask
  task automatic cyc();
    @(negedge clktx);
    compare();
    @(posedge clktx);
    mstep();
    #1;
  endtask
  initial begin
    mreset();
    #1 rst = 1;
    #1;
    chk("reset gnt_v", 32'(gnt_v), 0);
    chk("reset gnt_c", 32'(gnt_c), 0);
    chk("reset cmd_req", 32'(cmd_req), 0);
    chk("reset hs_mode", 32'(hs_mode), 0);
    chk("reset payload", payload, 0);
    cyc(); cyc();
    rst = 0;
    cyc();
    // short V packet with wc=0
    v_req = 1; v_hdr = 24'h000001;
    cyc();
    chk("t1 cmd_req", 32'(cmd_req), 1);
    chk("t1 dt", 32'(dt), 1);
    chk("t1 wc", 32'(bc), 0);
    chk("t1 gnt_v", 32'(gnt_v), 1);
    ack = 1; cyc(); ack = 0; v_req = 0;
    cyc();
    chk("t1 gap gnt_v", 32'(gnt_v), 1);
    cyc();
    chk("t1 released", 32'(gnt_v), 0);
    cyc();
    // long V packet, release waits on host_tx_active
    v_req = 1; v_long = 1; v_hdr = 24'h0CA83E; v_payload = 32'hDEADBEEF; active = 1;
    cyc();
    chk("t2 wc", 32'(bc), 3240);
    chk("t2 dt", 32'(dt), 32'h3E);
    ack = 1; cyc(); ack = 0; v_req = 0;
    pen = 1; cyc();
    chk("t2 payload", payload, 32'hDEADBEEF);
    last = 1; cyc(); last = 0; pen = 0;
    cyc(); cyc(); cyc();
    chk("t2 held while active", 32'(gnt_v), 1);
    active = 0; cyc();
    chk("t2 released", 32'(gnt_v), 0);
    v_long = 0;
    // C without blanking is never admitted
    c_req = 1; c_hdr = 24'h000505;
    for (int i = 0; i < 8; i++) begin cyc(); chk("t3 no blank gnt_c", 32'(gnt_c), 0); end
    // V and C together during blanking: V first, C after the gap
    v_req = 1; v_hdr = 24'h000011; blank = 1;
    cyc();
    chk("t3 v first", 32'(gnt_v), 1);
    ack = 1; cyc(); ack = 0; v_req = 0;
    for (int i = 0; i < 4; i++) cyc();
    chk("t3 c after gap", 32'(gnt_c), 1);
    ack = 1; cyc(); ack = 0; c_req = 0;
    for (int i = 0; i < 4; i++) cyc();
    // long C with wc=0 skips the payload phase
    c_req = 1; c_long = 1; c_hdr = 24'h000029; c_payload = 32'hFFFFFFFF;
    cyc();
    ack = 1; cyc(); ack = 0; c_req = 0; pen = 1; last = 1;
    cyc();
    chk("t6 payload stays 0", payload, 0);
    chk("t6 gnt_c in gap", 32'(gnt_c), 1);
    cyc(); pen = 0; last = 0; c_long = 0;
    cyc(); cyc();
    // V held with C pending during blanking
    v_req = 1; c_req = 1; blank = 1; ack = 1;
    for (int i = 0; i < 30; i++) begin
      cyc();
`ifndef MIPI_TX_ARB_AGING_EN
      chk("t4 no c while v_req", 32'(gnt_c), 0);
`endif
    end
    v_req = 0; c_req = 0; ack = 0;
    for (int i = 0; i < 6; i++) cyc();
    // reset in the payload phase
    v_req = 1; v_long = 1; v_hdr = 24'h00102A; active = 1;
    cyc(); ack = 1; cyc(); ack = 0;
    rst = 1;
    #1;
    chk("t5 gnt_v", 32'(gnt_v), 0);
    chk("t5 cmd_req", 32'(cmd_req), 0);
    chk("t5 hs_mode", 32'(hs_mode), 0);
    chk("t5 payload", payload, 0);
    chk("t5 byte_count", 32'(bc), 0);
    mreset();
    cyc();
    rst = 0; v_long = 0; active = 0; v_hdr = 24'h000002;
    cyc();
    chk("t5 regrant", 32'(gnt_v), 1);
    chk("t5 regrant dt", 32'(dt), 2);
    v_req = 0; ack = 1; cyc(); ack = 0;
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      v_req = $urandom_range(0, 1);
      c_req = $urandom_range(0, 1);
      blank = $urandom_range(0, 2) != 0;
      v_long = $urandom_range(0, 1);
      c_long = $urandom_range(0, 1);
      v_hdr = $urandom_range(0, 3) == 0 ? {16'd0, 8'($urandom)} : 24'($urandom);
      c_hdr = $urandom_range(0, 3) == 0 ? {16'd0, 8'($urandom)} : 24'($urandom);
      v_payload = $urandom;
      c_payload = $urandom;
      ack = $urandom_range(0, 2) == 0;
      active = $urandom_range(0, 1);
      pen = $urandom_range(0, 1);
      last = $urandom_range(0, 3) == 0;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
